// File: rtl/clk_div.sv
// rtl/clk_div.sv - integer clock divider with bypass; optional O_div_tick under CLK_DIV_TICK_EN
module clk_div #(
  parameter int WIDTH = 8
) (
  input  logic             I_ref_clk,
  input  logic             I_rst,
  input  logic             I_clk_en,
  input  logic [WIDTH-1:0] I_div_ratio,
`ifdef CLK_DIV_TICK_EN
  output logic             O_div_tick,
`endif
  output logic             O_div_clk
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] half_hi;
  logic [WIDTH-1:0] half_lo;
  logic [WIDTH-1:0] phase_last;
  logic             div_q;
  logic             active;
  logic             phase_done;

  // Ratios 0 and 1 cannot be divided, so they fall back to pass-through.
  assign active     = I_clk_en && (I_div_ratio >= WIDTH'(2));
  assign half_hi    = I_div_ratio >> 1;
  assign half_lo    = I_div_ratio - half_hi;
  // Only meaningful while active (ratio >= 2 keeps both halves >= 1).
  assign phase_last = (div_q ? half_hi : half_lo) - WIDTH'(1);
  // >= rather than == so a ratio lowered mid-phase ends the phase at once.
  assign phase_done = cnt >= phase_last;

  // Phase counter and divided-clock register; cleared whenever not dividing.
  always_ff @(posedge I_ref_clk) begin
    if (I_rst || !active) begin
      cnt   <= '0;
      div_q <= 1'b0;
    end else if (phase_done) begin
      cnt   <= '0;
      div_q <= ~div_q;
    end else begin
      cnt   <= cnt + WIDTH'(1);
    end
  end

  // Output mux: divided clock when active, raw reference otherwise.
  always_comb begin
    O_div_clk = I_ref_clk;
    if (active) begin
      O_div_clk = div_q;
    end
  end

`ifdef CLK_DIV_TICK_EN
  logic tick_q;

  // One-cycle pulse registered on the edge where div_q rises.
  always_ff @(posedge I_ref_clk) begin
    if (I_rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= active && phase_done && !div_q;
    end
  end

  // Gate with active so bypass forces the tick low without waiting an edge.
  always_comb begin
    O_div_tick = tick_q && active;
  end
`endif

endmodule

// File: tb/tb_clk_div.sv
// tb/tb_clk_div.sv - self-checking bench for clk_div (divide, bypass, reset, mid-run changes)
`timescale 1us/1ns
module tb_clk_div;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] ratio;
  logic         div_clk;
`ifdef CLK_DIV_TICK_EN
  logic         div_tick;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic exp_clk_q[$];
  logic exp_tick_q[$];

  clk_div #(.WIDTH(W)) dut (
    .I_ref_clk  (clk),
    .I_rst      (rst),
    .I_clk_en   (en),
    .I_div_ratio(ratio),
`ifdef CLK_DIV_TICK_EN
    .O_div_tick (div_tick),
`endif
    .O_div_clk  (div_clk)
  );

  // 10 us reference period
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_tick(input string tag, input logic exp);
`ifdef CLK_DIV_TICK_EN
    check(tag, div_tick, exp);
`endif
  endtask

  // Pass-through check: output follows the reference level in both halves.
  task automatic check_bypass(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check({tag, "_hi"}, div_clk, 1'b1);
      check_tick({tag, "_tick"}, 1'b0);
      @(negedge clk); #1;
      check({tag, "_lo"}, div_clk, 1'b0);
    end
  endtask

  // Enter reset while active: output must be held low through the reset cycle.
  task automatic reset_active(input logic [W-1:0] n);
    rst = 1'b1; en = 1'b1; ratio = n;
    @(posedge clk); #1;
    check("rst_hi", div_clk, 1'b0);
    check_tick("rst_tick", 1'b0);
    @(negedge clk); #1;
    check("rst_lo", div_clk, 1'b0);
    rst = 1'b0;
  endtask

  // Divide-by-n from the first active edge: after edge k, high iff (k mod n) >= ceil(n/2).
  task automatic run_div(input string tag, input int n, input int cycles);
    int l;
    logic e;
    l = n - n / 2;
    for (int k = 1; k <= cycles; k++) begin
      exp_clk_q.push_back((k % n) >= l);
      exp_tick_q.push_back((k % n) == l);
      @(posedge clk); #1;
      e = exp_clk_q.pop_front();
      check({tag, "_hi"}, div_clk, e);
      check_tick({tag, "_tick"}, exp_tick_q.pop_front());
      @(negedge clk); #1;
      check({tag, "_lo"}, div_clk, e);
    end
  endtask

  // Directed sequence from the scoreboard queues.
  task automatic run_queued(input string tag);
    logic e;
    while (exp_clk_q.size() != 0) begin
      @(posedge clk); #1;
      e = exp_clk_q.pop_front();
      check({tag, "_hi"}, div_clk, e);
      check_tick({tag, "_tick"}, exp_tick_q.pop_front());
      @(negedge clk); #1;
      check({tag, "_lo"}, div_clk, e);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ratio = 8'd1;

    // Bypass with enable low: pass-through even during reset.
    @(posedge clk); #1;
    check("bypass_rst_hi", div_clk, 1'b1);
    @(negedge clk); #1;
    check("bypass_rst_lo", div_clk, 1'b0);
    rst = 1'b0;
    check_bypass("bypass_en0", 3);

    // Enabled with ratio 1 and ratio 0: still pass-through.
    rst = 1'b1; en = 1'b1; ratio = 8'd1;
    @(negedge clk); #1;
    rst = 1'b0;
    check_bypass("ratio1", 3);
    ratio = 8'd0;
    check_bypass("ratio0", 2);

    // Even ratios: 50% duty, first rise after N/2 edges.
    reset_active(8'd2); run_div("div2", 2, 6);
    reset_active(8'd4); run_div("div4", 4, 12);
    reset_active(8'd6); run_div("div6", 6, 18);
    reset_active(8'd8); run_div("div8", 8, 24);

    // Odd ratios: low phase one cycle longer than high.
    reset_active(8'd3); run_div("div3", 3, 9);
    reset_active(8'd5); run_div("div5", 5, 15);
    reset_active(8'd7); run_div("div7", 7, 21);

    // Largest ratio exercises the counter width.
    reset_active(8'd255); run_div("div255", 255, 260);

    // Ratio 8 -> 2 with cnt=3 in the low phase: toggle next edge, then 1/1.
    reset_active(8'd8); run_div("mid_pre", 8, 3);
    ratio = 8'd2;
    exp_clk_q.push_back(1'b1); exp_tick_q.push_back(1'b1);
    exp_clk_q.push_back(1'b0); exp_tick_q.push_back(1'b0);
    exp_clk_q.push_back(1'b1); exp_tick_q.push_back(1'b1);
    exp_clk_q.push_back(1'b0); exp_tick_q.push_back(1'b0);
    run_queued("mid_8to2");

    // Enable drop while div_q is high: immediate bypass, then full low phase.
    reset_active(8'd4); run_div("en_pre", 4, 6);
    check("en_pre_high", div_clk, 1'b1);
    en = 1'b0; #1;
    check("en_drop_now", div_clk, 1'b0);
    check_tick("en_drop_tick", 1'b0);
    check_bypass("en_off", 2);
    en = 1'b1;
    run_div("en_restart", 4, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
